count_sequence_checker: RTL and testbench
=========================================

COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

Interface
REQ-001 The block SHALL have parameter WRAP_W, default 8, meaning the width of the wrap counter.
REQ-002 The block SHALL have parameter SYNC_LEN, default 2, meaning the number of consecutive +1 steps required to lock (legal range 1..15).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates occur on the rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-005 The block SHALL have port q_in  input  2  meaning the count value from the upstream 2-bit counter.
REQ-006 The block SHALL have port clr_err  input  1  meaning a request to clear a fault and restart acquisition.
REQ-007 The block SHALL have port locked  output  1  meaning the checker is in the TRACK state.
REQ-008 The block SHALL have port wrap_pulse  output  1  meaning a one-cycle pulse per detected 3->0 wrap.
REQ-009 The block SHALL have port wrap_count  output  WRAP_W  meaning the number of wraps detected while locked.
REQ-010 The block SHALL have port err  output  1  meaning a sticky sequence-violation flag.

Function
REQ-011 The block SHALL register q_in into q_prev on every rising edge of clk while reset is low.
REQ-012 The block SHALL classify each sampled q_in against q_prev as HOLD (equal), STEP (q_prev+1 mod 4) or ILLEGAL (any other value).
REQ-013 The block SHALL implement the states IDLE, SYNC, TRACK and FAULT, with IDLE as the reset state.
REQ-014 In IDLE, the block SHALL capture q_in into q_prev, clear sync_cnt and move to SYNC on the next edge, without classifying that sample.
REQ-015 In SYNC, the block SHALL increment sync_cnt on STEP, hold it on HOLD, and clear it to 0 on ILLEGAL, staying in SYNC and leaving err unchanged.
REQ-016 In SYNC, when a STEP brings sync_cnt to SYNC_LEN, the block SHALL move to TRACK at that same edge.
REQ-017 In TRACK, HOLD and STEP SHALL keep the state, and ILLEGAL SHALL move to FAULT and set err at that edge.
REQ-018 In TRACK, a STEP with q_prev=3 and q_in=0 SHALL be a wrap, setting wrap_pulse=1 for exactly one cycle and incrementing wrap_count at that edge.
REQ-019 All outputs SHALL be registered, so wrap_pulse and the new wrap_count become visible in the cycle after the edge that sampled q_in=0.
REQ-020 wrap_count SHALL saturate at 2^WRAP_W-1, with no rollover, and further wraps at saturation SHALL still pulse wrap_pulse.
REQ-021 A wrap SHALL NOT be counted or pulsed in IDLE, SYNC or FAULT, including the STEP that completes SYNC.
REQ-022 locked SHALL be 1 exactly when the state register is TRACK.
REQ-023 In FAULT, the block SHALL hold err=1 and ignore q_in classification while continuing to update q_prev.
REQ-024 clr_err sampled high in FAULT SHALL clear err and move to IDLE on that edge, and wrap_count SHALL be retained.
REQ-025 clr_err sampled high in IDLE, SYNC or TRACK SHALL have no effect.
REQ-026 An ILLEGAL sample and clr_err in the same TRACK cycle SHALL result in FAULT with err=1, because clr_err acts only in FAULT.

Reset
REQ-027 reset sampled high SHALL set state=IDLE, q_prev=0, sync_cnt=0, locked=0, wrap_pulse=0, wrap_count=0 and err=0, overriding every other input.
REQ-028 reset asserted mid-operation in any state, including FAULT, SHALL take effect at the next edge with the values of REQ-027.
REQ-029 reset SHALL have no asynchronous effect, so outputs change only on a clk rising edge.

Verification
REQ-030 Scenario: with a 10 ns clk and reset high for 100 ns, then q_in stepping 0,1,2,3,0 once per cycle -> all outputs are 0 during reset; locked=1 two STEPs after IDLE; wrap_pulse is high for one cycle after q_in=0 is sampled; wrap_count=1.
REQ-031 Scenario: q_in held constant for 20 cycles after reset -> the state stays in SYNC with locked=0, err=0 and wrap_count=0.
REQ-032 Scenario: locked, then q_in jumps 1->3 -> err=1 and locked=0 the next cycle; further wraps are not counted; clr_err pulsed -> err=0, and relock occurs after 2 STEPs with wrap_count retained.
REQ-033 Scenario: with WRAP_W=2, 5 wraps while locked -> wrap_count reads 1,2,3,3,3 and wrap_pulse fires 5 times.
REQ-034 Scenario: an ILLEGAL sample in SYNC after 1 STEP, then 2 STEPs -> no err, and locked=1 only after the 2 STEPs that follow the illegal sample.
REQ-035 Scenario: reset asserted for 1 cycle while in FAULT with wrap_count=3 -> all outputs are 0 after that edge, and the state is IDLE.

Source files
------------

// File: rtl/count_sequence_checker_if.sv
// Signal bundle between an upstream 2-bit counter and its sequence checker.
// The master drives the count samples; the slave reports lock, wrap and fault status.
interface count_sequence_checker_if #(
    parameter int WRAP_W = 8
);
    logic [1:0]        q_in;
    logic              clr_err;
    logic              locked;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              err;

    modport master (
        output q_in, clr_err,
        input  locked, wrap_pulse, wrap_count, err
    );

    modport slave (
        input  q_in, clr_err,
        output locked, wrap_pulse, wrap_count, err
    );
endinterface

// File: rtl/count_sequence_checker.sv
// Watches a free-running 2-bit counter, locks after SYNC_LEN clean +1 steps,
// counts 3->0 wraps while locked, and latches a sticky error on any illegal jump.
module count_sequence_checker #(
    parameter int WRAP_W   = 8,
    parameter int SYNC_LEN = 2
) (
    input logic                     clk,
    input logic                     reset,
    count_sequence_checker_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [3:0] SYNC_TGT = 4'(SYNC_LEN);

    logic [1:0]        state_reg, state_next;
    logic [1:0]        q_prev_reg, q_prev_next;
    logic [3:0]        sync_cnt_reg, sync_cnt_next;
    logic [WRAP_W-1:0] wrap_count_reg, wrap_count_next;
    logic              wrap_pulse_reg, wrap_pulse_next;
    logic              err_reg, err_next;

    logic [1:0] q_succ;
    logic       is_hold;
    logic       is_step;
    logic       is_wrap;
    logic       count_sat;

    assign q_succ    = q_prev_reg + 2'd1;
    assign is_hold   = (bus.q_in == q_prev_reg);
    assign is_step   = (bus.q_in == q_succ);
    assign is_wrap   = is_step && (q_prev_reg == 2'd3);
    assign count_sat = &wrap_count_reg;

    always_comb begin
        state_next      = state_reg;
        q_prev_next     = bus.q_in;
        sync_cnt_next   = sync_cnt_reg;
        wrap_count_next = wrap_count_reg;
        wrap_pulse_next = 1'b0;
        err_next        = err_reg;

        case (state_reg)
            ST_IDLE: begin
                // First sample after reset/clear only seeds q_prev.
                sync_cnt_next = 4'd0;
                state_next    = ST_SYNC;
            end
            ST_SYNC: begin
                if (is_step) begin
                    sync_cnt_next = sync_cnt_reg + 4'd1;
                    if ((sync_cnt_reg + 4'd1) == SYNC_TGT) begin
                        state_next = ST_TRACK;
                    end
                end else if (!is_hold) begin
                    sync_cnt_next = 4'd0;
                end
            end
            ST_TRACK: begin
                if (!is_step && !is_hold) begin
                    state_next = ST_FAULT;
                    err_next   = 1'b1;
                end else if (is_wrap) begin
                    wrap_pulse_next = 1'b1;
                    if (!count_sat) begin
                        wrap_count_next = wrap_count_reg + 1'b1;
                    end
                end
            end
            default: begin
                // Fault: samples are still tracked but never classified.
                err_next = 1'b1;
                if (bus.clr_err) begin
                    err_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            q_prev_reg     <= 2'd0;
            sync_cnt_reg   <= 4'd0;
            wrap_count_reg <= '0;
            wrap_pulse_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            q_prev_reg     <= q_prev_next;
            sync_cnt_reg   <= sync_cnt_next;
            wrap_count_reg <= wrap_count_next;
            wrap_pulse_reg <= wrap_pulse_next;
            err_reg        <= err_next;
        end
    end

    assign bus.locked     = (state_reg == ST_TRACK);
    assign bus.wrap_pulse = wrap_pulse_reg;
    assign bus.wrap_count = wrap_count_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed scoreboard bench: each driven cycle queues the hand-computed outputs
// expected after the next rising edge; a monitor pops and compares them.
module tb_count_sequence_checker;
    localparam int W = 2;

    typedef struct {
        logic         l;
        logic         p;
        logic [W-1:0] c;
        logic         e;
        string        nm;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   pass_cnt;
    int   total_cnt;

    count_sequence_checker_if #(.WRAP_W(W)) bus ();

    count_sequence_checker #(.WRAP_W(W), .SYNC_LEN(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv(input logic r, input logic [1:0] q, input logic clr,
                       input logic el, input logic ep, input int ec, input logic ee,
                       input string nm);
        exp_t x;
        @(negedge clk);
        reset       = r;
        bus.q_in    = q;
        bus.clr_err = clr;
        x.l  = el;
        x.p  = ep;
        x.c  = W'(ec);
        x.e  = ee;
        x.nm = nm;
        sb.push_back(x);
    endtask

    // Monitor: outputs are sampled 1 ns after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                total_cnt++;
                if (bus.locked === x.l && bus.wrap_pulse === x.p &&
                    bus.wrap_count === x.c && bus.err === x.e) begin
                    pass_cnt++;
                    $display("ok   %s: locked=%0b pulse=%0b count=%0d err=%0b",
                             x.nm, bus.locked, bus.wrap_pulse, bus.wrap_count, bus.err);
                end else begin
                    $display("FAIL %s: got locked=%0b pulse=%0b count=%0d err=%0b, want locked=%0b pulse=%0b count=%0d err=%0b",
                             x.nm, bus.locked, bus.wrap_pulse, bus.wrap_count, bus.err,
                             x.l, x.p, x.c, x.e);
                end
            end
        end
    end

    initial begin
        int c;
        pass_cnt    = 0;
        total_cnt   = 0;
        reset       = 1'b1;
        bus.q_in    = 2'd0;
        bus.clr_err = 1'b0;

        // Reset for 100 ns, then a single pass 0,1,2,3,0.
        for (int i = 0; i < 10; i++) drv(1, 0, 0, 0, 0, 0, 0, "reset_hold");
        drv(0, 0, 0, 0, 0, 0, 0, "a_idle");
        drv(0, 1, 0, 0, 0, 0, 0, "a_step1");
        drv(0, 2, 0, 1, 0, 0, 0, "a_lock");
        drv(0, 3, 0, 1, 0, 0, 0, "a_step3");
        drv(0, 0, 0, 1, 1, 1, 0, "a_wrap");
        drv(0, 0, 0, 1, 0, 1, 0, "a_pulse_gone");

        // Constant input never locks; clr_err outside FAULT is ignored.
        drv(1, 2, 0, 0, 0, 0, 0, "b_reset");
        for (int i = 0; i < 20; i++)
            drv(0, 2, (i % 4 == 1), 0, 0, 0, 0, "b_hold");

        // Lock (completing step is 3->0 and must not count), wrap, fault, clear, relock.
        drv(0, 3, 0, 0, 0, 0, 0, "c_step1");
        drv(0, 0, 0, 1, 0, 0, 0, "c_lock_on_wrap");
        drv(0, 1, 0, 1, 0, 0, 0, "c_t1");
        drv(0, 2, 0, 1, 0, 0, 0, "c_t2");
        drv(0, 3, 0, 1, 0, 0, 0, "c_t3");
        drv(0, 0, 0, 1, 1, 1, 0, "c_wrap");
        drv(0, 1, 0, 1, 0, 1, 0, "c_t1b");
        drv(0, 3, 1, 0, 0, 1, 1, "c_illegal_with_clr");
        drv(0, 0, 0, 0, 0, 1, 1, "c_fault_wrap_ignored");
        drv(0, 1, 1, 0, 0, 1, 0, "c_clear");
        drv(0, 2, 0, 0, 0, 1, 0, "c_idle");
        drv(0, 3, 0, 0, 0, 1, 0, "c_resync1");
        drv(0, 0, 0, 1, 0, 1, 0, "c_relock");

        // Narrow counter saturates at 3 but keeps pulsing.
        drv(1, 0, 0, 0, 0, 0, 0, "d_reset");
        drv(0, 0, 0, 0, 0, 0, 0, "d_idle");
        drv(0, 1, 0, 0, 0, 0, 0, "d_step1");
        drv(0, 2, 0, 1, 0, 0, 0, "d_lock");
        drv(0, 3, 0, 1, 0, 0, 0, "d_t3");
        drv(0, 0, 0, 1, 1, 1, 0, "d_wrap1");
        for (int k = 2; k <= 5; k++) begin
            c = (k > 3) ? 3 : k;
            drv(0, 1, 0, 1, 0, (k > 4) ? 3 : k - 1, 0, "d_t1");
            drv(0, 2, 0, 1, 0, (k > 4) ? 3 : k - 1, 0, "d_t2");
            drv(0, 3, 0, 1, 0, (k > 4) ? 3 : k - 1, 0, "d_t3");
            drv(0, 0, 0, 1, 1, c, 0, "d_wrap");
        end
        drv(0, 0, 0, 1, 0, 3, 0, "d_sat_hold");

        // Illegal sample in SYNC restarts acquisition without raising err.
        drv(1, 0, 0, 0, 0, 0, 0, "e_reset");
        drv(0, 0, 0, 0, 0, 0, 0, "e_idle");
        drv(0, 1, 0, 0, 0, 0, 0, "e_step1");
        drv(0, 3, 0, 0, 0, 0, 0, "e_illegal");
        drv(0, 0, 0, 0, 0, 0, 0, "e_step_a");
        drv(0, 0, 0, 0, 0, 0, 0, "e_hold");
        drv(0, 1, 0, 1, 0, 0, 0, "e_lock");

        // Reach FAULT with wrap_count=3, then a one-cycle reset.
        for (int k = 1; k <= 3; k++) begin
            drv(0, 2, 0, 1, 0, k - 1, 0, "f_t2");
            drv(0, 3, 0, 1, 0, k - 1, 0, "f_t3");
            drv(0, 0, 0, 1, 1, k, 0, "f_wrap");
            drv(0, 1, 0, 1, 0, k, 0, "f_t1");
        end
        drv(0, 3, 0, 0, 0, 3, 1, "f_illegal");
        drv(1, 1, 0, 0, 0, 0, 0, "f_reset_in_fault");
        drv(0, 1, 0, 0, 0, 0, 0, "f_idle");
        drv(0, 2, 0, 0, 0, 0, 0, "f_step1");
        drv(0, 3, 0, 1, 0, 0, 0, "f_relock");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
